dpram_sclk_be_init: RTL and testbench
=====================================

Name: dpram_sclk_be_init

Overview:
- Single-clock simple dual-port RAM: one write port, one read port.
- Next generation of the team's sync dual-port RAM, used under sync FIFOs and lookup tables.
- Adds per-byte write enables, an optional output pipeline register and a read-valid strobe.
- Adds a hardware init sequencer that sweeps the whole array after reset, so clear/index init works in silicon, not only in simulation.

Parameters:
- ADDR_WIDTH, 9, address bits; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 16, word width; must be a multiple of 8.
- NUM_BYTES, DATA_WIDTH/8, byte lanes (derived; do not override).
- INIT_MODE, 0, post-reset fill. 0 = all zeros; 1 = mem[i] = i (zero-extended or truncated to DATA_WIDTH); 2 = no sweep.
- OUT_REG, 0, 1 adds one output register stage (read latency 2 instead of 1).
- BYPASS, 0, collision policy. 1 = write-first forwarding on same-address read+write; 0 = read-first (old data).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- raddr  in  ADDR_WIDTH  read address.
- re  in  1  read enable.
- waddr  in  ADDR_WIDTH  write address.
- we  in  1  write enable.
- wbe  in  NUM_BYTES  byte write enables; bit i covers din[8i+7:8i].
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  one-cycle pulse, aligned with dout, per accepted read.
- init_busy  out  1  high while the init sweep runs.
- init_done  out  1  high once the array is initialised; user access allowed.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: dout=0, dout_valid=0, init_done=0, pipeline registers=0.
  - init_busy=1 while rst is high, except INIT_MODE=2, where init_busy=0.
- Init FSM states: INIT, DONE.
  - rst forces INIT with sweep counter=0.
  - INIT: each cycle after rst deasserts, write init value to mem[counter] (all bytes), then counter+1.
  - When counter = 2^ADDR_WIDTH-1 is written, go to DONE; init_busy falls and init_done rises on the next edge.
  - Sweep length is exactly 2^ADDR_WIDTH cycles.
  - INIT_MODE=2: go straight to DONE; init_done=1 on the first edge after rst falls; contents left unchanged.
  - rst asserted mid-sweep restarts the sweep from address 0.
  - init_done never deasserts except on rst.
- User access gating: while not DONE, re, we and wbe are ignored (dropped, not queued). dout_valid stays 0.
- Write: when we is high, bytes with wbe[i]=1 are written at the clock edge; other bytes are unchanged. we with wbe=0 is a no-op.
- Read:
  - OUT_REG=0: re at cycle N → dout and dout_valid at cycle N+1.
  - OUT_REG=1: re at cycle N → dout and dout_valid at cycle N+2.
  - dout holds its last value when no read completes; no zeroing.
  - Back-to-back reads sustain full throughput.
- Collision (re & we, raddr==waddr, same cycle):
  - BYPASS=1: dout = din on lanes with wbe set, old data on the other lanes.
  - BYPASS=0: dout = old data.
  - Array contents are updated in both cases.
- Write followed by read of the same address in the next cycle returns the new data regardless of BYPASS.

Optional Feature:
- Macro: DPRAM_COLLISION_CNT_EN.
- Defined: adds output port coll_cnt [15:0], counting same-address re&we events accepted in DONE.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst.
  - Updates one cycle after the event.
- Undefined: port and counter are absent; no other behaviour changes.

Test Plan:
- Defaults (INIT_MODE=0): assert rst 3 cycles, release → init_busy high exactly 512 cycles, then init_done=1; reading addresses 0, 255, 511 returns 16'h0000 with dout_valid 1 cycle after re.
- INIT_MODE=1, DATA_WIDTH=16: after init_done, read 9'h1A5 → dout=16'h01A5; pulse rst at sweep counter 100 → sweep restarts at 0 and init_done is delayed a full 512 cycles from rst release.
- Write 16'hBEEF to addr 7 with wbe=2'b11, then 16'h12xx with wbe=2'b10 → read addr 7 returns 16'h12EF.
- BYPASS=1: addr 3 holds 16'h0000; same cycle we=1, wbe=2'b01, din=16'hAA55, re=1, raddr=3 → dout=16'h0055. With BYPASS=0 the same stimulus gives dout=16'h0000; a subsequent read gives 16'h0055.
- OUT_REG=1: re on 4 consecutive cycles to addresses 0–3 (values 10,11,12,13) → dout 10,11,12,13 on cycles N+2..N+5, with dout_valid high exactly those 4 cycles.
- During init_busy: drive we=1 at addr 5 with din=16'hFFFF and re=1 → no dout_valid; addr 5 reads the init value after init_done. With DPRAM_COLLISION_CNT_EN defined, 3 collisions → coll_cnt=3.

Source files
------------

// File: rtl/dpram_sclk_be_init.sv
// Single-clock dual-port RAM with byte enables, post-reset init sweep and optional out reg.
// Optional: define DPRAM_COLLISION_CNT_EN to add the coll_cnt same-address collision counter.
module dpram_sclk_be_init #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BYTES  = DATA_WIDTH / 8,
  parameter int INIT_MODE  = 0,
  parameter int OUT_REG    = 0,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [NUM_BYTES-1:0]  wbe,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  init_busy,
  output logic                  init_done
`ifdef DPRAM_COLLISION_CNT_EN
  ,
  output logic [15:0]           coll_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_INIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_we;
  logic [DATA_WIDTH-1:0] init_val;

  logic                  acc_ok, re_ok, we_ok;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_din;
  logic [NUM_BYTES-1:0]  m_be;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_fwd, rd_q;
  logic                  rd_v;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (INIT_MODE == 2) begin
          state_d = S_DONE;
        end else begin
          init_we = ~rst;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_val  = (INIT_MODE == 1) ? DATA_WIDTH'(cnt_q) : '0;
  assign init_busy = (state_q == S_INIT) && (INIT_MODE != 2);
  assign init_done = (state_q == S_DONE);

  // user traffic is dropped until the sweep has finished
  assign acc_ok = (state_q == S_DONE) && !rst;
  assign re_ok  = re & acc_ok;
  assign we_ok  = we & acc_ok;

  always_comb begin
    m_we   = we_ok;
    m_addr = waddr;
    m_din  = din;
    m_be   = wbe;
    if (init_we) begin
      m_we   = 1'b1;
      m_addr = cnt_q;
      m_din  = init_val;
      m_be   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (m_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (m_be[i]) mem[m_addr][8*i +: 8] <= m_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_fwd = mem[raddr];
    if (BYPASS != 0 && we_ok && waddr == raddr) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wbe[i]) rd_fwd[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= re_ok;
      if (re_ok) rd_q <= rd_fwd;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] o_q;
      logic                  o_v;
      always_ff @(posedge clk) begin
        if (rst) begin
          o_q <= '0;
          o_v <= 1'b0;
        end else begin
          o_v <= rd_v;
          if (rd_v) o_q <= rd_q;
        end
      end
      assign dout       = o_q;
      assign dout_valid = o_v;
    end else begin : g_nreg
      assign dout       = rd_q;
      assign dout_valid = rd_v;
    end
  endgenerate

`ifdef DPRAM_COLLISION_CNT_EN
  logic [15:0] coll_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= '0;
    end else if (re_ok && we_ok && raddr == waddr && coll_q != 16'hFFFF) begin
      coll_q <= coll_q + 16'd1;
    end
  end
  assign coll_cnt = coll_q;
`endif

endmodule

// File: tb/tb_dpram_sclk_be_init.sv
// Scoreboard bench: three instances (zero/read-first, index/out-reg/bypass, no-sweep)
// driven with the same stimulus and checked every cycle.
module tb_dpram_sclk_be_init;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NB = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] raddr = '0;
  logic          re = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic          we = 1'b0;
  logic [NB-1:0] wbe = '0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout_a, dout_b, dout_c;
  logic          dv_a, dv_b, dv_c;
  logic          busy_a, busy_b, busy_c;
  logic          done_a, done_b, done_c;
`ifdef DPRAM_COLLISION_CNT_EN
  logic [15:0]   coll_a, coll_b, coll_c;
  logic [15:0]   coll_exp;
`endif

  always #5 clk = ~clk;

  dpram_sclk_be_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MODE(0), .OUT_REG(0), .BYPASS(0)
  ) u_a (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .we(we),
    .wbe(wbe), .din(din), .dout(dout_a), .dout_valid(dv_a),
    .init_busy(busy_a), .init_done(done_a)
`ifdef DPRAM_COLLISION_CNT_EN
    , .coll_cnt(coll_a)
`endif
  );

  dpram_sclk_be_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MODE(1), .OUT_REG(1), .BYPASS(1)
  ) u_b (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .we(we),
    .wbe(wbe), .din(din), .dout(dout_b), .dout_valid(dv_b),
    .init_busy(busy_b), .init_done(done_b)
`ifdef DPRAM_COLLISION_CNT_EN
    , .coll_cnt(coll_b)
`endif
  );

  dpram_sclk_be_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MODE(2), .OUT_REG(0), .BYPASS(0)
  ) u_c (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .we(we),
    .wbe(wbe), .din(din), .dout(dout_c), .dout_valid(dv_c),
    .init_busy(busy_c), .init_done(done_c)
`ifdef DPRAM_COLLISION_CNT_EN
    , .coll_cnt(coll_c)
`endif
  );

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] la, lb;
  logic          pend_c;
  int            cyc;
  int            relcnt;
  int            n_run;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic ev;
    @(posedge clk);
    cyc++;
    if (rst) begin
      relcnt = 0;
      qa.delete();
      qb.delete();
      la = '0;
      lb = '0;
      pend_c = 1'b0;
`ifdef DPRAM_COLLISION_CNT_EN
      coll_exp = '0;
`endif
    end else begin
      relcnt++;
    end
    #1;
    chk("busy_a", busy_a, relcnt < DEPTH);
    chk("done_a", done_a, relcnt >= DEPTH);
    chk("busy_b", busy_b, relcnt < DEPTH);
    chk("done_b", done_b, relcnt >= DEPTH);
    chk("busy_c", busy_c, 1'b0);
    chk("done_c", done_c, relcnt >= 1);
    chk("valid_c", dv_c, pend_c);
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    chk("valid_a", dv_a, ev);
    if (ev) begin
      la = qa[0].d;
      void'(qa.pop_front());
    end
    chk("dout_a", dout_a, la);
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    chk("valid_b", dv_b, ev);
    if (ev) begin
      lb = qb[0].d;
      void'(qb.pop_front());
    end
    chk("dout_b", dout_b, lb);
`ifdef DPRAM_COLLISION_CNT_EN
    chk("coll_a", coll_a, coll_exp);
    chk("coll_b", coll_b, coll_exp);
`endif
  endtask

  task automatic drive(input logic r, input logic [AW-1:0] ra,
                       input logic w, input logic [AW-1:0] wa,
                       input logic [NB-1:0] be, input logic [DW-1:0] d);
    logic          acc;
    logic [DW-1:0] oa, ob;
    re = r; raddr = ra; we = w; waddr = wa; wbe = be; din = d;
    acc = !rst && relcnt >= DEPTH;
    pend_c = r && !rst && relcnt >= 1;
    if (acc && r) begin
      oa = mem_a[ra];
      ob = mem_b[ra];
      if (w && wa == ra) begin
        for (int i = 0; i < NB; i++) if (be[i]) ob[8*i +: 8] = d[8*i +: 8];
      end
      qa.push_back('{due: cyc + 1, d: oa});
      qb.push_back('{due: cyc + 2, d: ob});
    end
    if (acc && w) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_a[wa][8*i +: 8] = d[8*i +: 8];
          mem_b[wa][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
`ifdef DPRAM_COLLISION_CNT_EN
    if (acc && r && w && ra == wa && coll_exp != 16'hFFFF) coll_exp++;
`endif
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b1, a, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be,
                    input logic [DW-1:0] d);
    drive(1'b0, '0, 1'b1, a, be, d);
  endtask

  initial begin
    logic          r, w;
    logic [AW-1:0] ra, wa;
    logic [NB-1:0] be;
    logic [DW-1:0] d;
    cyc = 0; relcnt = 0; n_run = 0; n_fail = 0;
    la = '0; lb = '0; pend_c = 1'b0;
`ifdef DPRAM_COLLISION_CNT_EN
    coll_exp = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_b[i] = DW'(i);
    end

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(100);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(300);
    drive(1'b1, 9'd5, 1'b1, 9'd5, 2'b11, 16'hFFFF);
    idle(DEPTH - 301 + 2);

    rd(9'd0); rd(9'd255); rd(9'd511); rd(9'h1A5); rd(9'd5);
    idle(3);

    wr(9'd7, 2'b11, 16'hBEEF);
    wr(9'd7, 2'b10, 16'h1234);
    rd(9'd7);
    idle(3);

    drive(1'b1, 9'd3, 1'b1, 9'd3, 2'b01, 16'hAA55);
    rd(9'd3);
    idle(3);

    for (int i = 0; i < 4; i++) wr(AW'(i), 2'b11, DW'(10 + i));
    for (int i = 0; i < 4; i++) rd(AW'(i));
    idle(4);

    wr(9'd20, 2'b11, 16'h5A5A);
    rd(9'd20);
    drive(1'b1, 9'd20, 1'b1, 9'd20, 2'b10, 16'hC3C3);
    drive(1'b1, 9'd21, 1'b1, 9'd21, 2'b00, 16'h7777);
    idle(3);

    for (int n = 0; n < 300; n++) begin
      r  = 1'($urandom_range(1));
      w  = 1'($urandom_range(1));
      ra = AW'($urandom_range(7));
      wa = AW'($urandom_range(7));
      be = NB'($urandom_range(3));
      d  = DW'($urandom);
      drive(r, ra, w, wa, be, d);
    end
    idle(4);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
